mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port mult_ex  input  1  start multiply, from decode/execute register.
REQ-005 SHALL have port div_ex  input  1  start divide.
REQ-006 SHALL have port signed_ex  input  1  1 = signed (mult/div), 0 = unsigned (multu/divu).
REQ-007 SHALL have ports mthi_ex, mtlo_ex  input  1 each  write HI/LO from rs_val.
REQ-008 SHALL have ports mfhi_ex, mflo_ex  input  1 each  read HI/LO.
REQ-009 SHALL have port rs_val  input  XLEN  operand A (dividend / multiplicand / mthi-mtlo data).
REQ-010 SHALL have port rt_val  input  XLEN  operand B (divisor / multiplier).
REQ-011 SHALL have port hilo_rd  output  XLEN  mfhi_ex ? HI : LO, combinational.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE, decoded from registered state.
REQ-013 SHALL have port stall  output  1  busy & (any of the six command inputs), combinational.
REQ-014 SHALL have port div_zero  output  1  last divide had rt_val = 0; sticky until next accepted mult/div.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIX.
REQ-016 SHALL accept a start only in IDLE; if mult_ex and div_ex are both high, SHALL treat it as multiply.
REQ-017 SHALL ignore commands arriving while busy, leaving HI/LO/state unaffected.
REQ-018 SHALL, on start, latch magnitudes of rs_val/rt_val (two's-complement absolute value if signed_ex, raw otherwise) plus result sign flags, clear a 5-bit counter, and enter MUL or DIV.
REQ-019 SHALL, in MUL, perform one shift-add step per cycle over 32 cycles (counter 0..31), producing a 64-bit unsigned product.
REQ-020 SHALL, in DIV, perform one restoring shift-subtract step per cycle over 32 cycles, producing a 32-bit quotient and remainder.
REQ-021 SHALL go from MUL/DIV to FIX when counter = 31, and from FIX to IDLE unconditionally.
REQ-022 SHALL, in FIX, apply signs and write HI/LO at the end of that cycle.
REQ-023 SHALL apply multiply signs as: product negated when the operand signs differ (signed only), with {HI,LO} = 64-bit result.
REQ-024 SHALL apply divide signs as: LO = quotient, negated when the operand signs differ; HI = remainder, taking the dividend's sign.
REQ-025 SHALL give latency as: start sampled at edge E; busy high for cycles E+1..E+33; HI/LO valid and busy low from E+34.
REQ-026 SHALL, when divisor = 0, produce the unsigned-datapath result LO = 0xFFFFFFFF, HI = |A|, sign-fixed per REQ-024, with the same latency and div_zero = 1.
REQ-027 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce LO = 0x80000000, HI = 0, without a fault.
REQ-028 SHALL, for mthi_ex/mtlo_ex in IDLE with no start, write HI/LO = rs_val at that edge, visible the next cycle; a simultaneous mthi and mtlo SHALL write both.
REQ-029 SHALL give a start priority over mthi/mtlo asserted in the same cycle; the move SHALL be discarded.
REQ-030 SHALL keep hilo_rd reflecting only committed HI/LO, never intermediate values.

Reset
REQ-031 SHALL, on reset low at any time including mid-operation, force state IDLE, HI = LO = 0, counter = 0, div_zero = 0, and discard in-flight operands.
REQ-032 SHALL hold busy = 0 and stall = 0 during and immediately after reset.
REQ-033 SHALL accept a start on the first rising edge after reset deasserts.

Verification
REQ-034 SHALL check unsigned mult 0xFFFFFFFF x 0xFFFFFFFF -> at E+34 HI = 0xFFFFFFFE, LO = 0x00000001; busy high exactly 33 cycles.
REQ-035 SHALL check signed div -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; signed mult -3 x 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
REQ-036 SHALL check divu 100 / 0 -> LO = 0xFFFFFFFF, HI = 100, div_zero = 1, cleared by the next mult.
REQ-037 SHALL check a second mult issued at E+5 -> stall = 1, command ignored, result equals the first operation's result only.
REQ-038 SHALL check reset pulsed at E+10 of a div -> HI = LO = 0, busy = 0 next cycle; a new mult then completes normally.
REQ-039 SHALL check mthi 0x12345678 then mfhi next cycle -> hilo_rd = 0x12345678; mtlo together with mult -> LO = product low, not rs_val.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle shift-add multiplier / restoring divider owning the HI/LO pair
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   mult_ex    start multiply (wins over div_ex when both are high)
//   div_ex     start divide
//   signed_ex  1 = signed operation, 0 = unsigned
//   mthi_ex    write HI from rs_val when idle and not starting
//   mtlo_ex    write LO from rs_val when idle and not starting
//   mfhi_ex    select HI onto hilo_rd (LO otherwise)
//   mflo_ex    read LO (only affects stall)
//   rs_val     dividend / multiplicand / move data
//   rt_val     divisor / multiplier
//   hilo_rd    committed HI or LO
//   busy       operation in flight
//   stall      command presented while busy
//   div_zero   last accepted divide had a zero divisor
module mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mult_ex,
    input  logic            div_ex,
    input  logic            signed_ex,
    input  logic            mthi_ex,
    input  logic            mtlo_ex,
    input  logic            mfhi_ex,
    input  logic            mflo_ex,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic [XLEN-1:0] hilo_rd,
    output logic            busy,
    output logic            stall,
    output logic            div_zero
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_d;
    logic [XLEN-1:0]   hi, lo, opnd, rs_mag, rt_mag, quo_fix, rem_fix;
    logic [2*XLEN-1:0] p, prod_fix, mul_next, div_next;
    logic [XLEN:0]     mul_sum, div_tmp, div_diff;
    logic [4:0]        cnt;
    logic              start, rs_neg, rt_neg, neg_res, neg_a, is_div, div_ok;

    assign start   = (state == IDLE) & (mult_ex | div_ex);
    assign rs_neg  = signed_ex & rs_val[XLEN-1];
    assign rt_neg  = signed_ex & rt_val[XLEN-1];
    assign rs_mag  = rs_neg ? -rs_val : rs_val;
    assign rt_mag  = rt_neg ? -rt_val : rt_val;
    // Multiply: p = {partial product, remaining multiplier bits}; add then shift right.
    assign mul_sum  = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, p[0] ? opnd : {XLEN{1'b0}}};
    assign mul_next = {mul_sum, p[XLEN-1:1]};
    // Divide: p = {remainder, dividend bits / quotient bits}; shift left, trial subtract.
    assign div_tmp  = p[2*XLEN-1:XLEN-1];
    assign div_diff = div_tmp - {1'b0, opnd};
    assign div_ok   = ~div_diff[XLEN];
    assign div_next = {div_ok ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0], p[XLEN-2:0], div_ok};
    assign prod_fix = neg_res ? -p : p;
    assign quo_fix  = neg_res ? -p[XLEN-1:0] : p[XLEN-1:0];
    assign rem_fix  = neg_a ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    assign hilo_rd  = mfhi_ex ? hi : lo;
    assign busy     = state != IDLE;
    assign stall    = busy & (mult_ex | div_ex | mthi_ex | mtlo_ex | mfhi_ex | mflo_ex);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        state_d = state == IDLE ? (mult_ex ? MUL : div_ex ? DIV : IDLE) :
                  state == FIX  ? IDLE :
                  cnt == 5'd31  ? FIX : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi       <= '0;
            lo       <= '0;
            p        <= '0;
            opnd     <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            neg_a    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            opnd     <= mult_ex ? rs_mag : rt_mag;
            p        <= {{XLEN{1'b0}}, mult_ex ? rt_mag : rs_mag};
            neg_res  <= rs_neg ^ rt_neg;
            neg_a    <= rs_neg;
            is_div   <= ~mult_ex;
            cnt      <= '0;
            div_zero <= ~mult_ex & (rt_val == '0);
        end else if (state == IDLE) begin
            if (mthi_ex) hi <= rs_val;
            if (mtlo_ex) lo <= rs_val;
        end else if (state == FIX) begin
            {hi, lo} <= is_div ? {rem_fix, quo_fix} : prod_fix;
        end else begin
            p   <= state == MUL ? mul_next : div_next;
            cnt <= cnt + 5'd1;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
    logic        clk, reset, mult_ex, div_ex, signed_ex, mthi_ex, mtlo_ex, mfhi_ex, mflo_ex;
    logic [31:0] rs_val, rt_val, hilo_rd;
    logic        busy, stall, div_zero;
    int          n_cmp = 0;
    int          n_fail = 0;

    mult_div_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .mult_ex(mult_ex), .div_ex(div_ex), .signed_ex(signed_ex),
        .mthi_ex(mthi_ex), .mtlo_ex(mtlo_ex), .mfhi_ex(mfhi_ex), .mflo_ex(mflo_ex),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_rd(hilo_rd), .busy(busy), .stall(stall),
        .div_zero(div_zero)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Returns {HI, LO} using plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(logic d, logic s, logic [31:0] a, logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, rm;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (!d) return sa * sb;
        if (b == 0) begin
            q = 32'hFFFFFFFF;
            if (s && a[31]) q = -q;
            return {a, q};
        end
        q  = 32'(sa / sb);
        rm = 32'(sa % sb);
        return {rm, q};
    endfunction

    task automatic issue(input logic m, d, s, mh, ml, input logic [31:0] a, b);
        mult_ex = m; div_ex = d; signed_ex = s; mthi_ex = mh; mtlo_ex = ml; rs_val = a; rt_val = b;
        @(negedge clk);
        mult_ex = 0; div_ex = 0; mthi_ex = 0; mtlo_ex = 0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, l);
        mfhi_ex = 1; mflo_ex = 0;
        #1 h = hilo_rd;
        mfhi_ex = 0; mflo_ex = 1;
        #1 l = hilo_rd;
        mflo_ex = 0;
    endtask

    task automatic exec(input logic m, d, s, ml, input logic [31:0] a, b,
                        output int cyc, output logic [31:0] h, l);
        issue(m, d, s, 1'b0, ml, a, b);
        wait_idle(cyc);
        read_hilo(h, l);
    endtask

    task automatic test_reset;
        logic [31:0] h, l;
        int cyc;
        mult_ex = 1; signed_ex = 0; rs_val = 3; rt_val = 4;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", stall); end
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_divzero got %b exp 0", div_zero); end
        read_hilo(h, l);
        n_cmp++; if ({h, l} !== 64'd0) begin n_fail++; $display("FAIL rst_hilo got %h exp 0", {h, l}); end
        reset = 1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_release_stall got %b exp 0", stall); end
        @(negedge clk);
        mult_ex = 0;
        wait_idle(cyc);
        n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL first_start_busy got %0d exp 33", cyc); end
        read_hilo(h, l);
        n_cmp++; if ({h, l} !== 64'd12) begin n_fail++; $display("FAIL first_start_result got %h exp %h", {h, l}, 64'd12); end
    endtask

    task automatic test_directed;
        logic [31:0] h, l;
        int cyc;
        exec(1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, h, l);
        n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL umul_busy got %0d exp 33", cyc); end
        n_cmp++; if (h !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL umul_hi got %h exp fffffffe", h); end
        n_cmp++; if (l !== 32'h00000001) begin n_fail++; $display("FAIL umul_lo got %h exp 00000001", l); end
        exec(0, 1, 1, 0, -32'sd7, 32'd2, cyc, h, l);
        n_cmp++; if ({h, l} !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin n_fail++; $display("FAIL sdiv got %h exp ffffffff_fffffffd", {h, l}); end
        exec(1, 0, 1, 0, -32'sd3, 32'd5, cyc, h, l);
        n_cmp++; if ({h, l} !== {32'hFFFFFFFF, 32'hFFFFFFF1}) begin n_fail++; $display("FAIL smul got %h exp ffffffff_fffffff1", {h, l}); end
        exec(0, 1, 0, 0, 32'd100, 32'd0, cyc, h, l);
        n_cmp++; if ({h, l} !== {32'd100, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL divu_zero got %h exp 00000064_ffffffff", {h, l}); end
        n_cmp++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL divzero_set got %b exp 1", div_zero); end
        n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL divzero_busy got %0d exp 33", cyc); end
        exec(1, 0, 0, 0, 32'd2, 32'd3, cyc, h, l);
        n_cmp++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL divzero_clear got %b exp 0", div_zero); end
        n_cmp++; if (l !== 32'd6) begin n_fail++; $display("FAIL mul_after_dz got %h exp 6", l); end
        exec(0, 1, 1, 0, 32'h80000000, 32'hFFFFFFFF, cyc, h, l);
        n_cmp++; if ({h, l} !== {32'd0, 32'h80000000}) begin n_fail++; $display("FAIL sdiv_ovf got %h exp 00000000_80000000", {h, l}); end
        exec(1, 1, 0, 0, 32'd7, 32'd3, cyc, h, l);
        n_cmp++; if ({h, l} !== 64'd21) begin n_fail++; $display("FAIL mul_div_both got %h exp %h", {h, l}, 64'd21); end
    endtask

    task automatic test_random;
        logic [31:0] h, l, a, b;
        logic d, s;
        logic [63:0] exp;
        int cyc;
        for (int i = 0; i < 40; i++) begin
            d = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom_range(0, 7) == 0 ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 15)) : $urandom;
            if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            exp = ref_model(d, s, a, b);
            exec(~d, d, s, 0, a, b, cyc, h, l);
            n_cmp++; if ({h, l} !== exp) begin n_fail++; $display("FAIL rand%0d d=%b s=%b a=%h b=%h got %h exp %h", i, d, s, a, b, {h, l}, exp); end
            n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL rand%0d_busy got %0d exp 33", i, cyc); end
            n_cmp++; if (div_zero !== (d && b == 0)) begin n_fail++; $display("FAIL rand%0d_divzero got %b exp %b", i, div_zero, d && b == 0); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] h, l;
        int cyc;
        issue(1, 0, 1, 0, 0, 32'h00012345, 32'hFFFF0001);
        wait_idle(cyc);
        issue(0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h00001234);
        wait_idle(cyc);
        n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL b2b_busy got %0d exp 33", cyc); end
        read_hilo(h, l);
        n_cmp++; if ({h, l} !== ref_model(1, 0, 32'hDEADBEEF, 32'h00001234)) begin n_fail++; $display("FAIL b2b got %h exp %h", {h, l}, ref_model(1, 0, 32'hDEADBEEF, 32'h00001234)); end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] h, l;
        int cyc;
        issue(1, 0, 0, 0, 0, 32'h0000BEEF, 32'h00C0FFEE);
        repeat (4) @(negedge clk);
        mult_ex = 1; mthi_ex = 1; rs_val = 32'h11111111; rt_val = 32'h22222222;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL busy_stall got %b exp 1", stall); end
        @(negedge clk);
        mult_ex = 0; mthi_ex = 0;
        wait_idle(cyc);
        n_cmp++; if (cyc !== 28) begin n_fail++; $display("FAIL busy_remaining got %0d exp 28", cyc); end
        read_hilo(h, l);
        n_cmp++; if ({h, l} !== 64'h0000BEEF * 64'h00C0FFEE) begin n_fail++; $display("FAIL busy_ignore got %h exp %h", {h, l}, 64'h0000BEEF * 64'h00C0FFEE); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] h, l;
        int cyc;
        exec(1, 0, 0, 0, 32'hABCD0123, 32'h12345678, cyc, h, l);
        issue(0, 1, 0, 0, 0, 32'd100, 32'd0);
        repeat (9) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || div_zero !== 1'b1) begin n_fail++; $display("FAIL mid_pre got busy=%b dz=%b exp 1 1", busy, div_zero); end
        reset = 0;
        #1;
        n_cmp++; if (busy !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL mid_rst got busy=%b dz=%b exp 0 0", busy, div_zero); end
        read_hilo(h, l);
        n_cmp++; if ({h, l} !== 64'd0) begin n_fail++; $display("FAIL mid_rst_hilo got %h exp 0", {h, l}); end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_busy got %b exp 0", busy); end
        exec(1, 0, 0, 0, 32'd1234, 32'd5678, cyc, h, l);
        n_cmp++; if ({h, l} !== 64'd7006652 || cyc !== 33) begin n_fail++; $display("FAIL mid_newmul got %h cyc %0d exp %h cyc 33", {h, l}, cyc, 64'd7006652); end
    endtask

    task automatic test_move;
        logic [31:0] h, l;
        int cyc;
        issue(0, 0, 0, 1, 0, 32'h12345678, 32'd0);
        mfhi_ex = 1;
        #1;
        n_cmp++; if (hilo_rd !== 32'h12345678) begin n_fail++; $display("FAIL mthi got %h exp 12345678", hilo_rd); end
        mfhi_ex = 0;
        issue(0, 0, 0, 1, 1, 32'hCAFEF00D, 32'd0);
        read_hilo(h, l);
        n_cmp++; if ({h, l} !== {32'hCAFEF00D, 32'hCAFEF00D}) begin n_fail++; $display("FAIL mthi_mtlo got %h exp cafef00d_cafef00d", {h, l}); end
        exec(1, 0, 0, 1, 32'h00010001, 32'h00000100, cyc, h, l);
        n_cmp++; if ({h, l} !== {32'd0, 32'h01000100}) begin n_fail++; $display("FAIL mtlo_with_mult got %h exp 00000000_01000100", {h, l}); end
    endtask

    initial begin
        reset = 1; mult_ex = 0; div_ex = 0; signed_ex = 0; mthi_ex = 0; mtlo_ex = 0;
        mfhi_ex = 0; mflo_ex = 0; rs_val = 0; rt_val = 0;
        #3 reset = 0;
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_busy_ignore;
        test_reset_mid;
        test_move;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
